fyp_rx_stats: RTL and testbench
===============================

# fyp_rx_stats

Avalon-ST sink that terminates the TSE MAC receive interface (32-bit, 125 MHz system clock domain) and turns received traffic into frame, byte and error statistics for the packet generator. It always accepts data, delineates frames using SOP/EOP, classifies each frame as good, errored, runt or oversize, and keeps saturating counters. A snapshot register bank gives a coherent set of values to readers. A retriggerable activity strobe drives a user LED.

## Interface
- `CNT_W`, 32: width of every statistics counter.
- `BYTE_CNT_W`, 48: width of the good-byte counter.
- `MIN_BYTES`, 60: minimum legal delivered frame length in bytes (CRC stripped by MAC).
- `MAX_BYTES`, 1514: maximum legal delivered frame length in bytes.
- `ACT_HOLD`, 6250000: activity strobe hold time in clk cycles (50 ms).

- `clk`  in  1  125 MHz system clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `rx_data`  in  32  Avalon-ST data, big-endian byte order (bits 31:24 = first byte).
- `rx_valid`  in  1  beat valid.
- `rx_sop`  in  1  start of packet.
- `rx_eop`  in  1  end of packet.
- `rx_empty`  in  2  unused bytes in EOP beat; ignored when `rx_eop`=0.
- `rx_err`  in  6  MAC error flags; sampled on EOP beat only.
- `rx_rdy`  out  1  sink ready.
- `stats_clear`  in  1  single-cycle pulse; zeroes all live counters.
- `stats_snap`  in  1  single-cycle pulse; copies live counters into snapshot outputs.
- `snap_frames_good`, `snap_frames_err`, `snap_frames_runt`, `snap_frames_long`, `snap_seq_err`  out  CNT_W  snapshot counters.
- `snap_bytes_good`  out  BYTE_CNT_W  snapshot good-byte total.
- `activity`  out  1  high for `ACT_HOLD` cycles after each good frame.

## Operation
- A beat is accepted when `rx_valid` & `rx_rdy`. `rx_rdy` = 0 in reset and 1 otherwise; there is no back-pressure.
- FSM `IDLE` / `IN_FRAME`:
  - IDLE + SOP&EOP beat: single-beat frame, classified immediately; stay IDLE.
  - IDLE + SOP beat: beat counter = 1, go to IN_FRAME.
  - IDLE + non-SOP beat: discarded, `frames_err` += 1 once per orphan EOP. Non-EOP orphans are not counted.
  - IN_FRAME + beat: beat counter += 1. On EOP, classify the frame and go to IDLE.
  - IN_FRAME + SOP: the open frame counts as `frames_err`; a new frame starts with beat counter = 1.
- Length = 4 × beats − `rx_empty`. The beat counter is 12 bits and saturates at 4095. A saturated frame is oversize.
- Classification, first match wins:
  1. Any `rx_err` bit set → `frames_err`.
  2. Length < MIN_BYTES → `frames_runt`.
  3. Length > MAX_BYTES → `frames_long`.
  4. Otherwise → `frames_good` += 1 and `bytes_good` += length.
- Exactly one class counter increments per frame.
- All counters saturate at all-ones and never wrap.
- `stats_clear` zeroes the live counters and the sequence tracker. If a frame classifies in the same cycle, the clear wins and that frame is not counted.
- `stats_snap` copies all live counters into the snapshot outputs.
- `activity` reloads its hold counter on every good frame and is retriggerable.

## Timing
- All outputs are 0 during reset and on the first cycle after reset. `rx_rdy` rises on the first cycle with `resetn` = 1.
- Live counters update one cycle after the EOP beat.
- Snapshot outputs update one cycle after `stats_snap`. They reflect live values from before any update that lands in the same cycle as the snap. A frame whose EOP is accepted in cycle N is included in a snap issued in cycle N+1 or later.
- `activity` rises one cycle after the EOP beat of a good frame.
- A reset mid-frame discards the partial frame and returns the FSM to IDLE.

## Configuration
- `FYP_RX_SEQ_CHECK_EN` defined:
  - Word index 4 of each good frame (bytes 16–19) is a 32-bit generator sequence number.
  - The first good frame after reset or clear loads the tracker.
  - Each later good frame whose number ≠ previous + 1 (mod 2^32) increments `seq_err`, then the tracker resyncs to the received value.
  - A good frame shorter than 5 beats does not touch the tracker.
- Not defined: no capture logic, and `snap_seq_err` is tied to 0.

## Structure
- Package `fyp_eth_pkg`:
  - FSM state typedef.
  - `rx_err` bit-index constants.
  - Default MIN/MAX frame-length constants.
  - Sequence-word index constant (4).
- Sub-module `fyp_sat_counter`, parameterised width, with inputs `inc`, `inc_val`, `clr`. Instantiated once per counter.

## Test plan
- 10 back-to-back 64-byte good frames (16 beats, empty = 0), then snap → good = 10, bytes = 640, all other counters 0, `activity` = 1.
- One 15-beat frame with empty = 3 (57 bytes) → runt = 1. One 379-beat frame with empty = 0 (1516 bytes) → long = 1.
- Frame with `rx_err` = 6'b000010 on EOP → err = 1, good unchanged. SOP mid-frame followed by a valid 64-byte frame → err = 1, good = 1.
- `stats_clear` in the same cycle as a good frame's classification, then snap → all counters 0.
- Reset asserted mid-frame, then a fresh 64-byte frame → good = 1. During reset, `rx_rdy` = 0 and every snapshot output = 0.
- With `FYP_RX_SEQ_CHECK_EN`, sequences 5, 6, 8, 9 → `seq_err` = 1. Without the macro → `seq_err` = 0.

Source files
------------

// File: rtl/fyp_eth_pkg.sv
// Shared types and constants for the Ethernet receive statistics block:
// FSM state, frame classification, MAC error-flag bit positions and
// default frame-length limits.
package fyp_eth_pkg;

  // Frame delineation FSM states.
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } rx_state_e;

  // Outcome of a frame that has just closed; CLS_NONE means no frame closed.
  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_ERR  = 3'd1,
    CLS_RUNT = 3'd2,
    CLS_LONG = 3'd3,
    CLS_GOOD = 3'd4
  } rx_class_e;

  // TSE MAC rx_err flag positions (any set bit marks the frame errored).
  localparam int RX_ERR_W            = 6;
  localparam int RX_ERR_PHY_BIT      = 0;
  localparam int RX_ERR_OVERSIZE_BIT = 1;
  localparam int RX_ERR_LENGTH_BIT   = 2;
  localparam int RX_ERR_NONALIGN_BIT = 3;
  localparam int RX_ERR_CRC_BIT      = 4;
  localparam int RX_ERR_COLLIDE_BIT  = 5;

  // Default delivered-length limits (CRC already stripped by the MAC).
  localparam int DEF_MIN_BYTES = 60;
  localparam int DEF_MAX_BYTES = 1514;

  // Word index (0-based) of the generator sequence number inside a frame.
  localparam int SEQ_WORD_IDX = 4;

  // Beat counter saturates at all-ones; length needs two extra bits (x4).
  localparam int BEAT_CNT_W = 12;
  localparam int LEN_W      = BEAT_CNT_W + 2;

  // First-match classification of a closed frame.
  function automatic rx_class_e classify_frame(
    input logic [RX_ERR_W-1:0] err,
    input logic [LEN_W-1:0]    len,
    input logic                beat_sat,
    input int                  min_bytes,
    input int                  max_bytes
  );
    if (|err)                                 return CLS_ERR;
    else if (int'(len) < min_bytes)           return CLS_RUNT;
    else if (beat_sat || int'(len) > max_bytes) return CLS_LONG;
    else                                      return CLS_GOOD;
  endfunction

endpackage

// File: rtl/fyp_rx_stats_if.sv
// Avalon-ST receive bus from the TSE MAC. The MAC side is the master,
// the statistics sink is the slave.
interface fyp_rx_stats_if;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic [1:0]  rx_empty;
  logic [5:0]  rx_err;
  logic        rx_rdy;

  modport master (
    output rx_data, rx_valid, rx_sop, rx_eop, rx_empty, rx_err,
    input  rx_rdy
  );

  modport slave (
    input  rx_data, rx_valid, rx_sop, rx_eop, rx_empty, rx_err,
    output rx_rdy
  );
endinterface

// File: rtl/fyp_sat_counter.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count sticks at all-ones instead of wrapping.
module fyp_sat_counter #(
  parameter int WIDTH = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic [INC_W-1:0] inc_val,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // Next count: clear, else saturating add of inc_val.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d = cnt_q;
    sum   = {1'b0, cnt_q} + {{(WIDTH + 1 - INC_W){1'b0}}, inc_val};
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops
    // sample the same pre-edge values.
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fyp_rx_stats.sv
// Receive statistics sink for the TSE MAC Avalon-ST interface. Always
// ready; delineates frames with SOP/EOP, classifies each closed frame and
// keeps saturating counters plus a coherent snapshot bank and an activity
// strobe. Optional build macro FYP_RX_SEQ_CHECK_EN adds a generator
// sequence-number checker; without it snap_seq_err reads 0.
module fyp_rx_stats
  import fyp_eth_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int BYTE_CNT_W = 48,
  parameter int MIN_BYTES  = DEF_MIN_BYTES,
  parameter int MAX_BYTES  = DEF_MAX_BYTES,
  parameter int ACT_HOLD   = 6250000
) (
  input  logic                  clk,
  input  logic                  resetn,
  fyp_rx_stats_if.slave         rx,
  input  logic                  stats_clear,
  input  logic                  stats_snap,
  output logic [CNT_W-1:0]      snap_frames_good,
  output logic [CNT_W-1:0]      snap_frames_err,
  output logic [CNT_W-1:0]      snap_frames_runt,
  output logic [CNT_W-1:0]      snap_frames_long,
  output logic [CNT_W-1:0]      snap_seq_err,
  output logic [BYTE_CNT_W-1:0] snap_bytes_good,
  output logic                  activity
);

  localparam int ACT_W = $clog2(ACT_HOLD + 1);

  // No back-pressure: ready whenever out of reset.
  assign rx.rx_rdy = resetn;

  // --------------------------------------------------------------------
  // Frame delineation
  // --------------------------------------------------------------------
  rx_state_e               state_q, state_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BEAT_CNT_W-1:0]   beats_now;
  logic [LEN_W-1:0]        frame_len;
  logic                    accept;
  logic                    in_frame_beat;
  logic                    abort_frame;
  logic                    orphan_eop;
  logic                    frame_end;
  rx_class_e               frame_cls;

  // Beat bookkeeping, frame close detection and classification.
  always_comb begin
    accept        = rx.rx_valid & resetn;
    in_frame_beat = accept & ((state_q == ST_IN_FRAME) | rx.rx_sop);
    abort_frame   = accept & (state_q == ST_IN_FRAME) & rx.rx_sop;
    orphan_eop    = accept & (state_q == ST_IDLE) & ~rx.rx_sop & rx.rx_eop;
    frame_end     = in_frame_beat & rx.rx_eop;

    // Beats in the current frame including this one; SOP restarts at 1.
    if ((state_q == ST_IN_FRAME) && !rx.rx_sop) begin
      beats_now = (beat_cnt_q == '1) ? '1 : beat_cnt_q + 1'b1;
    end else begin
      beats_now = BEAT_CNT_W'(1);
    end

    frame_len = {beats_now, 2'b00} - {{(LEN_W - 2){1'b0}}, rx.rx_empty};
    frame_cls = frame_end ? classify_frame(rx.rx_err, frame_len, beats_now == '1,
                                           MIN_BYTES, MAX_BYTES)
                          : CLS_NONE;

    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (in_frame_beat) begin
      beat_cnt_d = beats_now;
      state_d    = rx.rx_eop ? ST_IDLE : ST_IN_FRAME;
    end
  end

  // FSM state and beat counter; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // --------------------------------------------------------------------
  // Live counters
  // --------------------------------------------------------------------
  logic [CNT_W-1:0]      frames_good, frames_err, frames_runt, frames_long, seq_err;
  logic [BYTE_CNT_W-1:0] bytes_good;
  logic [1:0]            err_inc_val;
  logic                  is_good;

  // An aborting SOP beat can also close an errored single-beat frame.
  assign err_inc_val = {1'b0, abort_frame} + {1'b0, orphan_eop}
                     + {1'b0, frame_cls == CLS_ERR};
  assign is_good     = (frame_cls == CLS_GOOD);

  fyp_sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_cnt_good (
    .clk(clk), .resetn(resetn), .inc(is_good), .inc_val(1'b1),
    .clr(stats_clear), .cnt(frames_good)
  );

  fyp_sat_counter #(.WIDTH(CNT_W), .INC_W(2)) u_cnt_err (
    .clk(clk), .resetn(resetn), .inc(|err_inc_val), .inc_val(err_inc_val),
    .clr(stats_clear), .cnt(frames_err)
  );

  fyp_sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_cnt_runt (
    .clk(clk), .resetn(resetn), .inc(frame_cls == CLS_RUNT), .inc_val(1'b1),
    .clr(stats_clear), .cnt(frames_runt)
  );

  fyp_sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_cnt_long (
    .clk(clk), .resetn(resetn), .inc(frame_cls == CLS_LONG), .inc_val(1'b1),
    .clr(stats_clear), .cnt(frames_long)
  );

  fyp_sat_counter #(.WIDTH(BYTE_CNT_W), .INC_W(LEN_W)) u_cnt_bytes (
    .clk(clk), .resetn(resetn), .inc(is_good), .inc_val(frame_len),
    .clr(stats_clear), .cnt(bytes_good)
  );

  // --------------------------------------------------------------------
  // Sequence-number checker
  // --------------------------------------------------------------------
`ifdef FYP_RX_SEQ_CHECK_EN
  logic [31:0] seq_word_q, seq_word_d;
  logic [31:0] trk_val_q, trk_val_d;
  logic        trk_vld_q, trk_vld_d;
  logic [31:0] seq_rx;
  logic        seq_hit;
  logic        seq_bad;

  // Capture the sequence word and compare it against the tracker.
  always_comb begin
    seq_word_d = seq_word_q;
    if (in_frame_beat && (int'(beats_now) == SEQ_WORD_IDX + 1)) begin
      seq_word_d = rx.rx_data;
    end

    // The sequence word may arrive on the EOP beat itself.
    seq_rx  = (int'(beats_now) == SEQ_WORD_IDX + 1) ? rx.rx_data : seq_word_q;
    seq_hit = is_good && (int'(beats_now) > SEQ_WORD_IDX);
    seq_bad = seq_hit && trk_vld_q && (seq_rx != trk_val_q + 32'd1);

    trk_val_d = trk_val_q;
    trk_vld_d = trk_vld_q;
    if (stats_clear) begin
      trk_val_d = '0;
      trk_vld_d = 1'b0;
    end else if (seq_hit) begin
      trk_val_d = seq_rx;
      trk_vld_d = 1'b1;
    end
  end

  // Tracker registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      seq_word_q <= '0;
      trk_val_q  <= '0;
      trk_vld_q  <= 1'b0;
    end else begin
      seq_word_q <= seq_word_d;
      trk_val_q  <= trk_val_d;
      trk_vld_q  <= trk_vld_d;
    end
  end

  fyp_sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_cnt_seq (
    .clk(clk), .resetn(resetn), .inc(seq_bad), .inc_val(1'b1),
    .clr(stats_clear), .cnt(seq_err)
  );
`else
  assign seq_err = '0;
`endif

  // --------------------------------------------------------------------
  // Snapshot bank
  // --------------------------------------------------------------------
  logic [CNT_W-1:0]      snap_good_q, snap_good_d;
  logic [CNT_W-1:0]      snap_err_q, snap_err_d;
  logic [CNT_W-1:0]      snap_runt_q, snap_runt_d;
  logic [CNT_W-1:0]      snap_long_q, snap_long_d;
  logic [CNT_W-1:0]      snap_seq_q, snap_seq_d;
  logic [BYTE_CNT_W-1:0] snap_bytes_q, snap_bytes_d;

  // Copy pre-edge live values so same-cycle updates are not included.
  always_comb begin
    snap_good_d  = snap_good_q;
    snap_err_d   = snap_err_q;
    snap_runt_d  = snap_runt_q;
    snap_long_d  = snap_long_q;
    snap_seq_d   = snap_seq_q;
    snap_bytes_d = snap_bytes_q;
    if (stats_snap) begin
      snap_good_d  = frames_good;
      snap_err_d   = frames_err;
      snap_runt_d  = frames_runt;
      snap_long_d  = frames_long;
      snap_seq_d   = seq_err;
      snap_bytes_d = bytes_good;
    end
  end

  // Snapshot registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      snap_good_q  <= '0;
      snap_err_q   <= '0;
      snap_runt_q  <= '0;
      snap_long_q  <= '0;
      snap_seq_q   <= '0;
      snap_bytes_q <= '0;
    end else begin
      snap_good_q  <= snap_good_d;
      snap_err_q   <= snap_err_d;
      snap_runt_q  <= snap_runt_d;
      snap_long_q  <= snap_long_d;
      snap_seq_q   <= snap_seq_d;
      snap_bytes_q <= snap_bytes_d;
    end
  end

  assign snap_frames_good = snap_good_q;
  assign snap_frames_err  = snap_err_q;
  assign snap_frames_runt = snap_runt_q;
  assign snap_frames_long = snap_long_q;
  assign snap_seq_err     = snap_seq_q;
  assign snap_bytes_good  = snap_bytes_q;

  // --------------------------------------------------------------------
  // Activity strobe
  // --------------------------------------------------------------------
  logic [ACT_W-1:0] act_cnt_q, act_cnt_d;

  // Retriggerable hold counter, reloaded by every good frame.
  always_comb begin
    act_cnt_d = act_cnt_q;
    if (is_good)             act_cnt_d = ACT_W'(ACT_HOLD);
    else if (act_cnt_q != 0) act_cnt_d = act_cnt_q - 1'b1;
  end

  // Hold counter register.
  always_ff @(posedge clk) begin
    if (!resetn) act_cnt_q <= '0;
    else         act_cnt_q <= act_cnt_d;
  end

  assign activity = (act_cnt_q != '0);

endmodule

// File: tb/tb_fyp_rx_stats.sv
// Self-checking bench for fyp_rx_stats. A reference model tracks live
// counters as frames are driven; each snap pushes the expected snapshot
// into a scoreboard queue that is popped and compared once the DUT
// snapshot outputs have updated.
module tb_fyp_rx_stats;

  localparam int CNT_W  = 32;
  localparam int BYTE_W = 48;
  localparam int HOLD   = 40;

  typedef struct {
    logic [CNT_W-1:0]  good;
    logic [CNT_W-1:0]  err;
    logic [CNT_W-1:0]  runt;
    logic [CNT_W-1:0]  lng;
    logic [CNT_W-1:0]  seq;
    logic [BYTE_W-1:0] bytes;
  } snap_t;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              stats_clear = 1'b0;
  logic              stats_snap = 1'b0;
  logic [CNT_W-1:0]  snap_frames_good, snap_frames_err, snap_frames_runt;
  logic [CNT_W-1:0]  snap_frames_long, snap_seq_err;
  logic [BYTE_W-1:0] snap_bytes_good;
  logic              activity;

  fyp_rx_stats_if rx_if ();

  fyp_rx_stats #(
    .CNT_W(CNT_W), .BYTE_CNT_W(BYTE_W), .MIN_BYTES(60), .MAX_BYTES(1514),
    .ACT_HOLD(HOLD)
  ) dut (
    .clk(clk), .resetn(resetn), .rx(rx_if),
    .stats_clear(stats_clear), .stats_snap(stats_snap),
    .snap_frames_good(snap_frames_good), .snap_frames_err(snap_frames_err),
    .snap_frames_runt(snap_frames_runt), .snap_frames_long(snap_frames_long),
    .snap_seq_err(snap_seq_err), .snap_bytes_good(snap_bytes_good),
    .activity(activity)
  );

  always #4 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int unsigned m_good, m_err, m_runt, m_long, m_seq;
  longint unsigned m_bytes;
  logic [31:0] m_trk;
  bit          m_trk_vld;
  snap_t       exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    rx_if.rx_valid = 1'b0;
    rx_if.rx_sop   = 1'b0;
    rx_if.rx_eop   = 1'b0;
    rx_if.rx_empty = 2'd0;
    rx_if.rx_err   = 6'd0;
    rx_if.rx_data  = 32'd0;
  endtask

  task automatic model_clear();
    m_good = 0; m_err = 0; m_runt = 0; m_long = 0; m_seq = 0; m_bytes = 0;
    m_trk = 0; m_trk_vld = 0;
  endtask

  task automatic model_frame(input int beats, input int empty,
                             input logic [5:0] err, input logic [31:0] seq);
    int len;
    len = 4 * beats - empty;
    if (err != 0)       m_err++;
    else if (len < 60)   m_runt++;
    else if (len > 1514) m_long++;
    else begin
      m_good++;
      m_bytes += longint'(len);
      if (beats >= 5) begin
        if (m_trk_vld && seq != m_trk + 32'd1) m_seq++;
        m_trk = seq;
        m_trk_vld = 1;
      end
    end
  endtask

  task automatic drive_beat(input logic [31:0] data, input logic sop,
                            input logic eop, input logic [1:0] empty,
                            input logic [5:0] err, input logic clr);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_sop   = sop;
    rx_if.rx_eop   = eop;
    rx_if.rx_empty = empty;
    rx_if.rx_err   = err;
    rx_if.rx_data  = data;
    stats_clear    = clr;
    tick();
    bus_idle();
    stats_clear = 1'b0;
  endtask

  // Drives beats (SOP first; EOP last when close is set). Word 4 holds seq.
  task automatic send_frame(input int beats, input logic [1:0] empty,
                            input logic [5:0] err, input logic [31:0] seq,
                            input bit close, input bit clr_on_eop);
    for (int i = 0; i < beats; i++) begin
      logic last;
      last = close && (i == beats - 1);
      drive_beat((i == 4) ? seq : 32'hA500_0000 + i, i == 0, last,
                 last ? empty : 2'd0, last ? err : 6'd0, last && clr_on_eop);
    end
    if (close) begin
      if (clr_on_eop) model_clear();
      else            model_frame(beats, int'(empty), err, seq);
    end
  endtask

  // Issues a snap, queuing the expected snapshot, then scores the result.
  task automatic snap_and_score(input string tag);
    snap_t e, a;
    e.good  = m_good;
    e.err   = m_err;
    e.runt  = m_runt;
    e.lng   = m_long;
`ifdef FYP_RX_SEQ_CHECK_EN
    e.seq   = m_seq;
`else
    e.seq   = '0;
`endif
    e.bytes = m_bytes[BYTE_W-1:0];
    exp_q.push_back(e);
    stats_snap = 1'b1;
    tick();
    stats_snap = 1'b0;
    a.good = snap_frames_good; a.err = snap_frames_err; a.runt = snap_frames_runt;
    a.lng = snap_frames_long; a.seq = snap_seq_err; a.bytes = snap_bytes_good;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      n_tests += 5;
      if (a.good !== e.good) begin n_fail++; $display("FAIL %s good got %0d want %0d", tag, a.good, e.good); end
      if (a.err !== e.err) begin n_fail++; $display("FAIL %s err got %0d want %0d", tag, a.err, e.err); end
      if (a.runt !== e.runt) begin n_fail++; $display("FAIL %s runt got %0d want %0d", tag, a.runt, e.runt); end
      if (a.lng !== e.lng) begin n_fail++; $display("FAIL %s long got %0d want %0d", tag, a.lng, e.lng); end
      if (a.seq !== e.seq) begin n_fail++; $display("FAIL %s seq_err got %0d want %0d", tag, a.seq, e.seq); end
      if (a.bytes !== e.bytes) begin n_fail++; $display("FAIL %s bytes got %0d want %0d", tag, a.bytes, e.bytes); end
    end
  endtask

  task automatic check_outputs_zero(input string tag, input logic rdy_exp);
    n_tests += 3;
    if (rx_if.rx_rdy !== rdy_exp) begin
      n_fail++; $display("FAIL %s rx_rdy got %b want %b", tag, rx_if.rx_rdy, rdy_exp);
    end
    if (activity !== 1'b0) begin
      n_fail++; $display("FAIL %s activity got %b want 0", tag, activity);
    end
    if ({snap_frames_good, snap_frames_err, snap_frames_runt, snap_frames_long,
         snap_seq_err, snap_bytes_good} !== '0) begin
      n_fail++;
      $display("FAIL %s snapshots got good=%0d err=%0d runt=%0d long=%0d seq=%0d bytes=%0d want all 0",
               tag, snap_frames_good, snap_frames_err, snap_frames_runt,
               snap_frames_long, snap_seq_err, snap_bytes_good);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset", 1'b0);
    resetn = 1'b1;
    #1;
    check_outputs_zero("first_cycle", 1'b1);
    tick();
    model_clear();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) send_frame(16, 2'd0, 6'd0, 32'(k), 1, 0);
    n_tests++;
    if (activity !== 1'b1) begin
      n_fail++; $display("FAIL b2b activity got %b want 1", activity);
    end
    snap_and_score("b2b");
  endtask

  task automatic test_runt_long();
    send_frame(15, 2'd3, 6'd0, 32'h100, 1, 0);   // 57 bytes
    send_frame(379, 2'd0, 6'd0, 32'h101, 1, 0);  // 1516 bytes
    send_frame(1, 2'd0, 6'd0, 32'h102, 1, 0);    // single-beat SOP+EOP, 4 bytes
    send_frame(15, 2'd0, 6'd0, 32'd10, 1, 0);    // exactly 60 bytes: good
    send_frame(379, 2'd2, 6'd0, 32'd11, 1, 0);   // exactly 1514 bytes: good
    snap_and_score("runt_long");
  endtask

  task automatic test_errors();
    send_frame(16, 2'd0, 6'b000010, 32'h200, 1, 0);
    send_frame(8, 2'd0, 6'd0, 32'h201, 0, 0);     // left open
    m_err++;                                       // aborted by next SOP
    send_frame(16, 2'd0, 6'd0, 32'd12, 1, 0);
    drive_beat(32'h1, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0); // orphan EOP
    m_err++;
    drive_beat(32'h2, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0); // orphan non-EOP: ignored
    snap_and_score("errors");
  endtask

  task automatic test_clear_collision();
    send_frame(16, 2'd0, 6'd0, 32'd13, 1, 1);
    snap_and_score("clear_collide");
  endtask

  task automatic test_activity();
    repeat (HOLD + 5) tick();
    n_tests++;
    if (activity !== 1'b0) begin
      n_fail++; $display("FAIL act_idle activity got %b want 0", activity);
    end
    send_frame(16, 2'd0, 6'd0, 32'd100, 1, 0);
    n_tests++;
    if (activity !== 1'b1) begin
      n_fail++; $display("FAIL act_rise activity got %b want 1", activity);
    end
    repeat (HOLD - 1) tick();
    n_tests++;
    if (activity !== 1'b1) begin
      n_fail++; $display("FAIL act_hold activity got %b want 1", activity);
    end
    tick();
    n_tests++;
    if (activity !== 1'b0) begin
      n_fail++; $display("FAIL act_drop activity got %b want 0", activity);
    end
  endtask

  task automatic test_seq();
    stats_clear = 1'b1;
    tick();
    stats_clear = 1'b0;
    model_clear();
    send_frame(16, 2'd0, 6'd0, 32'd5, 1, 0);
    send_frame(16, 2'd0, 6'd0, 32'd6, 1, 0);
    send_frame(16, 2'd0, 6'd0, 32'd8, 1, 0);
    send_frame(16, 2'd0, 6'd0, 32'd9, 1, 0);
    snap_and_score("seq");
  endtask

  task automatic test_reset_midframe();
    send_frame(7, 2'd0, 6'd0, 32'h300, 0, 0);
    resetn = 1'b0;
    tick();
    check_outputs_zero("midframe_reset", 1'b0);
    tick();
    resetn = 1'b1;
    model_clear();
    send_frame(16, 2'd0, 6'd0, 32'h400, 1, 0);
    snap_and_score("after_reset");
  endtask

  initial begin
    bus_idle();
    model_clear();
    test_reset();
    test_back_to_back();
    test_runt_long();
    test_errors();
    test_clear_collision();
    test_activity();
    test_seq();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
